// File: rtl/parity_tx_arbiter.sv
// ============================================================================
// parity_tx_arbiter : two-requester round-robin arbiter feeding an odd-parity
// 16-bit MSB-first serialiser; optional frameCount via PARITY_TX_FRAMECOUNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module parity_tx_arbiter #(
    parameter int GAP_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid0,
    input  logic [14:0] reqData0,
    output logic        reqReady0,
    input  logic        reqValid1,
    input  logic [14:0] reqData1,
    output logic        reqReady1,
    output logic        serialOut,
    output logic        serialValid,
    output logic        frameStart,
    output logic        busy,
    output logic        lastGrant
`ifdef PARITY_TX_FRAMECOUNT_EN
    ,
    output logic [7:0]  frameCount
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    logic [1:0]  state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        last_grant_q, last_grant_d;

    logic        grant0, grant1;
    logic        idle;
    logic [14:0] sel_data;

    assign idle = (state_q == S_IDLE);

    // On a tie the requester that was not served last wins; reset blocks any handshake.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reqValid0 && reqValid1) begin
            grant1 = ~last_grant_q;
            grant0 = last_grant_q;
        end else begin
            grant0 = reqValid0;
            grant1 = reqValid1;
        end
    end

    assign reqReady0 = idle & grant0 & ~reset;
    assign reqReady1 = idle & grant1 & ~reset;
    assign sel_data  = reqReady0 ? reqData0 : reqData1;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (reqReady0 || reqReady1) begin
                    shift_d      = {sel_data, ~(^sel_data)};
                    bit_cnt_d    = 4'd0;
                    last_grant_d = reqReady1;
                    state_d      = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d   = {shift_q[14:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd15) begin
                    gap_cnt_d = 4'd0;
                    state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shift_q      <= 16'd0;
            bit_cnt_q    <= 4'd0;
            gap_cnt_q    <= 4'd0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign serialValid = (state_q == S_SHIFT);
    assign serialOut   = serialValid & shift_q[15];
    assign frameStart  = serialValid & (bit_cnt_q == 4'd0);
    assign busy        = ~idle;
    assign lastGrant   = last_grant_q;

`ifdef PARITY_TX_FRAMECOUNT_EN
    logic [7:0] frame_count_q;
    logic       frame_done;

    // A frame counts as complete on the edge that retires bit 0.
    assign frame_done = (state_q == S_SHIFT) && (bit_cnt_q == 4'd15);

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count_q <= 8'd0;
        end else if (frame_done) begin
            frame_count_q <= frame_count_q + 8'd1;
        end
    end

    assign frameCount = frame_count_q;
`endif

endmodule

`default_nettype wire
